chacha20_stream_xor: RTL and testbench

- Initiator and consumer for the chacha20_block keystream core.
- Builds the 16-word ChaCha20 input state from key, nonce and block counter, then pulses the core's start.
- Captures the 16-word keystream block and XORs it, one word per transfer, onto a valid/ready data stream.
- Sits between the data path and the core; the same operation serves encryption and decryption.

---
 rtl/chacha20_stream_xor_if.sv | 27 ++
 rtl/chacha20_stream_xor.sv | 155 +++++++++++++++
 tb/tb_chacha20_stream_xor.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chacha20_stream_xor_if.sv
`default_nettype none
// ============================================================================
// Module   : chacha20_stream_xor_if
// Desc     : valid/ready word stream into and out of the ChaCha20 XOR stage.
// Revision : 1.0
// ============================================================================
interface chacha20_stream_xor_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/chacha20_stream_xor.sv
`default_nettype none
// ============================================================================
// Module   : chacha20_stream_xor
// Desc     : drives a ChaCha20 block core and XORs its keystream onto a stream.
// Revision : 1.0
// ============================================================================
module chacha20_stream_xor #(
    parameter int BLK_LATENCY = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [255:0]         key_i,
    input  logic [95:0]          nonce_i,
    input  logic [31:0]          ctr_init_i,
    chacha20_stream_xor_if.slave s_if,
    output logic                 busy_o,
    output logic                 ctr_overflow_o,
    output logic                 blk_start_o,
    output logic [15:0][31:0]    blk_state_in_o,
    input  logic                 blk_done_i,
    input  logic [15:0][31:0]    blk_state_out_i
);

    localparam int                  c_wait_w    = $clog2(BLK_LATENCY + 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(BLK_LATENCY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GEN    = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t              state_q;
    logic [255:0]        key_q;
    logic [95:0]         nonce_q;
    logic [31:0]         ctr_q;
    logic [15:0][31:0]   ks_q;
    logic [3:0]          idx_q;
    logic [c_wait_w-1:0] wait_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic [31:0]         out_data_q;
    logic                blk_start_q;
    logic                ctr_overflow_q;

    logic                in_ready;
    logic                in_xfer;
    logic                out_xfer;
    logic [31:0]         out_data_d;
    logic [3:0]          idx_d;

    // A pending load owns the cycle, so no input word may slip in alongside it.
    assign in_ready   = (state_q == STREAM) && !load_i && (!out_valid_q || s_if.out_ready);
    assign in_xfer    = s_if.in_valid && in_ready;
    assign out_xfer   = out_valid_q && s_if.out_ready;
    assign out_data_d = s_if.in_data ^ ks_q[idx_q];
    assign idx_d      = idx_q + 4'd1;

    assign s_if.in_ready  = in_ready;
    assign s_if.out_valid = out_valid_q;
    assign s_if.out_data  = out_data_q;
    assign s_if.out_last  = out_last_q;

    assign busy_o         = (state_q != IDLE) || out_valid_q;
    assign ctr_overflow_o = ctr_overflow_q;
    assign blk_start_o    = blk_start_q;

    assign blk_state_in_o[0]  = 32'h61707865;
    assign blk_state_in_o[1]  = 32'h3320646e;
    assign blk_state_in_o[2]  = 32'h79622d32;
    assign blk_state_in_o[3]  = 32'h6b206574;
    assign blk_state_in_o[12] = ctr_q;

    for (genvar gi = 0; gi < 8; gi++) begin : g_key
        assign blk_state_in_o[4+gi] = key_q[32*gi +: 32];
    end

    for (genvar gj = 0; gj < 3; gj++) begin : g_nonce
        assign blk_state_in_o[13+gj] = nonce_q[32*gj +: 32];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            key_q          <= '0;
            nonce_q        <= '0;
            ctr_q          <= '0;
            ks_q           <= '0;
            idx_q          <= '0;
            wait_q         <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_data_q     <= '0;
            blk_start_q    <= 1'b0;
            ctr_overflow_q <= 1'b0;
        end else begin
            blk_start_q <= 1'b0;
            if (out_xfer) begin
                out_valid_q <= 1'b0;
            end
            if (load_i) begin
                key_q          <= key_i;
                nonce_q        <= nonce_i;
                ctr_q          <= ctr_init_i;
                ctr_overflow_q <= 1'b0;
                wait_q         <= '0;
                blk_start_q    <= 1'b1;
                state_q        <= GEN;
                // The last word of a finished message may still drain in IDLE.
                if (state_q != IDLE) begin
                    out_valid_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    GEN: begin
                        if (wait_q == c_wait_last) begin
                            if (blk_done_i) begin
                                ks_q    <= blk_state_out_i;
                                idx_q   <= '0;
                                state_q <= STREAM;
                            end
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
                    end
                    STREAM: begin
                        if (in_xfer) begin
                            out_data_q  <= out_data_d;
                            out_last_q  <= s_if.in_last;
                            out_valid_q <= 1'b1;
                            idx_q       <= idx_d;
                            if (s_if.in_last) begin
                                state_q <= IDLE;
                            end else if (idx_q == 4'd15) begin
                                if (ctr_q == 32'hFFFF_FFFF) begin
                                    ctr_overflow_q <= 1'b1;
                                    state_q        <= IDLE;
                                end else begin
                                    ctr_q       <= ctr_q + 32'd1;
                                    wait_q      <= '0;
                                    blk_start_q <= 1'b1;
                                    state_q     <= GEN;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chacha20_stream_xor.sv
`default_nettype none
// ============================================================================
// Module   : tb_chacha20_stream_xor
// Desc     : bench with a behavioural ChaCha20 core and keystream reference.
// Revision : 1.0
// ============================================================================
module tb_chacha20_stream_xor;

    localparam int LAT = 12;
    typedef logic [15:0][31:0] blk_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic [255:0] key = '0;
    logic [95:0]  nonce = '0;
    logic [31:0]  ctr_init = '0;
    logic         busy, ctr_overflow, blk_start;
    logic         blk_done = 1'b0;
    blk_t         blk_state_in;
    blk_t         blk_state_out = '0;
    logic         out_ready_r = 1'b1;

    chacha20_stream_xor_if sif();

    chacha20_stream_xor #(.BLK_LATENCY(LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_i         (load),
        .key_i          (key),
        .nonce_i        (nonce),
        .ctr_init_i     (ctr_init),
        .s_if           (sif),
        .busy_o         (busy),
        .ctr_overflow_o (ctr_overflow),
        .blk_start_o    (blk_start),
        .blk_state_in_o (blk_state_in),
        .blk_done_i     (blk_done),
        .blk_state_out_i(blk_state_out)
    );

    always #5 clk = ~clk;
    assign sif.out_ready = out_ready_r;

    int checks = 0;
    int failures = 0;
    int core_extra = 0;
    int core_cnt = 0;
    blk_t core_res;
    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    logic        last_q[$];
    logic [31:0] start_q[$];

    logic [31:0] rfc [16] = '{
        32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
        32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
        32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
        32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2
    };

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic blk_t qr(input blk_t x, input int a, input int b, input int c, input int d);
        logic [31:0] va, vb, vc, vd;
        va = x[a]; vb = x[b]; vc = x[c]; vd = x[d];
        va = va + vb; vd = rotl(vd ^ va, 16);
        vc = vc + vd; vb = rotl(vb ^ vc, 12);
        va = va + vb; vd = rotl(vd ^ va, 8);
        vc = vc + vd; vb = rotl(vb ^ vc, 7);
        x[a] = va; x[b] = vb; x[c] = vc; x[d] = vd;
        return x;
    endfunction

    function automatic blk_t chacha(input blk_t s);
        blk_t x;
        x = s;
        for (int r = 0; r < 10; r++) begin
            x = qr(x, 0, 4, 8, 12);  x = qr(x, 1, 5, 9, 13);
            x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
            x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12);
            x = qr(x, 2, 7, 8, 13);  x = qr(x, 3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) x[i] = x[i] + s[i];
        return x;
    endfunction

    function automatic blk_t ref_ks(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        blk_t s;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = c;
        for (int j = 0; j < 3; j++) s[13+j] = n[32*j +: 32];
        return chacha(s);
    endfunction

    // Stand-in for the block core: answers after LAT (+extra) cycles with garbage before then.
    always @(negedge clk) begin
        if (blk_start) begin
            core_res = chacha(blk_state_in);
            core_cnt = LAT + core_extra;
            for (int i = 0; i < 16; i++) blk_state_out[i] = $urandom;
            if (core_extra != 0) blk_done = 1'b0;
            start_q.push_back(blk_state_in[12]);
        end else if (core_cnt > 0) begin
            core_cnt = core_cnt - 1;
            if (core_cnt == 0) begin
                blk_state_out = core_res;
                blk_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
            out_q.push_back(sif.out_data);
            last_q.push_back(sif.out_last);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        @(negedge clk);
        load = 1'b1; key = k; nonce = n; ctr_init = c;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int tries;
        tries = 0;
        @(negedge clk);
        sif.in_valid = 1'b1; sif.in_data = d; sif.in_last = last;
        in_q.push_back(d);
        #1;
        while (sif.in_ready !== 1'b1 && tries < 300) begin
            @(negedge clk);
            #1;
            tries++;
        end
        chk("in_accept", 32'(sif.in_ready), 32'd1);
        if (sif.in_ready === 1'b1) @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int t;
        t = 0;
        while (out_q.size() < n && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_count", 32'(out_q.size()), 32'(n));
    endtask

    task automatic check_msg(input string tag, input logic [255:0] k, input logic [95:0] n,
                             input logic [31:0] c0, input int nw, input logic last_end);
        blk_t ks;
        ks = '0;
        for (int i = 0; i < nw; i++) begin
            if (i % 16 == 0) ks = ref_ks(k, n, c0 + 32'(i / 16));
            chk($sformatf("%s_w%0d", tag, i), out_q[i], in_q[i] ^ ks[i % 16]);
        end
        chk($sformatf("%s_last", tag), 32'(last_q[nw-1]), 32'(last_end));
        in_q.delete(); out_q.delete(); last_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [255:0] k;
        logic [95:0]  n;
        logic [31:0]  c, c2, held;
        blk_t         ks;
        int           cnt;

        sif.in_valid = 1'b0; sif.in_data = '0; sif.in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(sif.in_ready), 32'd0);
        chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_blk_start", 32'(blk_start), 32'd0);
        chk("rst_out_data", sif.out_data, 32'd0);
        rst_n = 1'b1;

        // RFC 8439 block function vector, zero plaintext.
        for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
        n = {32'h00000000, 32'h4a000000, 32'h09000000};
        start_q.delete();
        do_load(k, n, 32'd1);
        chk("rfc_blk_start", 32'(blk_start), 32'd1);
        chk("rfc_state_ctr", blk_state_in[12], 32'd1);
        chk("rfc_state_key0", blk_state_in[4], 32'h03020100);
        cnt = 0;
        while (sif.in_ready !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("rfc_ready_latency", 32'(cnt), 32'(LAT + 1));
        for (int i = 0; i < 16; i++) send_word(32'd0, i == 15);
        wait_outs(16);
        for (int i = 0; i < 16; i++) chk($sformatf("rfc_w%0d", i), out_q[i], rfc[i]);
        chk("rfc_last", 32'(last_q[15]), 32'd1);
        in_q.delete(); out_q.delete(); last_q.delete();

        // Two-block message with a slow core.
        core_extra = 3;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        n = {$urandom, $urandom, $urandom};
        start_q.delete();
        do_load(k, n, 32'd1);
        for (int i = 0; i < 20; i++) send_word($urandom, i == 19);
        @(negedge clk);
        chk("two_busy_tail", 32'(busy), 32'd1);
        chk("two_out_last", 32'(sif.out_last), 32'd1);
        @(negedge clk);
        chk("two_busy_idle", 32'(busy), 32'd0);
        wait_outs(20);
        check_msg("two", k, n, 32'd1, 20, 1'b1);
        chk("two_starts", 32'(start_q.size()), 32'd2);
        chk("two_ctr2", start_q[1], 32'd2);
        core_extra = 0;

        // Backpressure in the middle of a block.
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        n = {$urandom, $urandom, $urandom};
        c = $urandom & 32'h7FFF_FFFF;
        do_load(k, n, c);
        for (int i = 0; i < 8; i++) send_word($urandom, 1'b0);
        ks = ref_ks(k, n, c);
        held = in_q[7] ^ ks[7];
        @(negedge clk);
        out_ready_r = 1'b0;
        sif.in_valid = 1'b1; sif.in_data = 32'hA5A5A5A5; sif.in_last = 1'b1;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            chk("bp_in_ready", 32'(sif.in_ready), 32'd0);
            chk("bp_out_valid", 32'(sif.out_valid), 32'd1);
            chk("bp_out_data", sif.out_data, held);
        end
        @(negedge clk);
        sif.in_valid = 1'b0;
        out_ready_r = 1'b1;
        for (int i = 8; i < 16; i++) send_word($urandom, i == 15);
        wait_outs(16);
        check_msg("bp", k, n, c, 16, 1'b1);

        // Counter exhaustion at the end of block 0xFFFFFFFF.
        start_q.delete();
        do_load(k, n, 32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++) send_word($urandom, 1'b0);
        @(negedge clk);
        chk("ovf_flag", 32'(ctr_overflow), 32'd1);
        sif.in_valid = 1'b1; sif.in_data = 32'h12345678; sif.in_last = 1'b0;
        #1;
        chk("ovf_in_ready", 32'(sif.in_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("ovf_in_ready2", 32'(sif.in_ready), 32'd0);
        sif.in_valid = 1'b0;
        wait_outs(16);
        check_msg("ovf", k, n, 32'hFFFF_FFFF, 16, 1'b0);
        chk("ovf_busy", 32'(busy), 32'd0);
        chk("ovf_starts", 32'(start_q.size()), 32'd1);
        c = 32'd5;
        do_load(k, n, c);
        chk("ovf_cleared", 32'(ctr_overflow), 32'd0);

        // Abort at idx 7 with a word held in the output register.
        for (int i = 0; i < 7; i++) send_word($urandom, 1'b0);
        @(negedge clk);
        out_ready_r = 1'b0;
        c2 = 32'h00AB_CDEF;
        do_load(~k, n, c2);
        chk("abort_out_valid", 32'(sif.out_valid), 32'd0);
        chk("abort_blk_start", 32'(blk_start), 32'd1);
        chk("abort_ctr", blk_state_in[12], c2);
        out_ready_r = 1'b1;
        chk("abort_outs", 32'(out_q.size()), 32'd6);
        check_msg("pre_abort", k, n, c, 6, 1'b0);
        for (int i = 0; i < 3; i++) send_word($urandom, i == 2);
        wait_outs(3);
        check_msg("post_abort", ~k, n, c2, 3, 1'b1);

        // Reset while a block is being generated.
        do_load(k, ~n, 32'd9);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_blk_start", 32'(blk_start), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ovf", 32'(ctr_overflow), 32'd0);
        chk("mid_rst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(sif.in_ready), 32'd0);
        chk("mid_rst_out_data", sif.out_data, 32'd0);
        chk("mid_rst_ctr", blk_state_in[12], 32'd0);
        chk("mid_rst_key0", blk_state_in[4], 32'd0);
        chk("mid_rst_sigma0", blk_state_in[0], 32'h61707865);
        rst_n = 1'b1;
        do_load(k, n, 32'd77);
        for (int i = 0; i < 2; i++) send_word($urandom, i == 1);
        wait_outs(2);
        check_msg("after_rst", k, n, 32'd77, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
